// File: rtl/i2c_reg_bridge.sv
// Register-file bridge between an I2C slave byte stage and a host port.
// The first byte after each (repeated) start sets the register pointer; later bytes write and auto-increment.
module i2c_reg_bridge (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] datareceive,
    input  logic       received,
    output logic [7:0] datasend,
    input  logic       sended,
    input  logic [3:0] hostaddr,
    input  logic       hostwe,
    input  logic [7:0] hostwdata,
    output logic [7:0] hostrdata,
    output logic       regwr,
    output logic [3:0] regaddr,
    output logic [3:0] pointer
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PTR  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] pointer_q, pointer_d;
    logic       regwr_q, regwr_d;
    logic [3:0] regaddr_q, regaddr_d;
    logic       received_q, received_d;
    logic       sended_q, sended_d;
    logic [7:0] regs_q [16];
    logic [7:0] regs_d [16];

    logic rcv_edge;
    logic snd_edge;
    logic i2c_we;
    logic ptr_load;

    // Levels from the slave stage may stay high for many cycles; only the rise counts.
    assign received_d = received;
    assign sended_d   = sended;
    assign rcv_edge   = received & ~received_q;
    assign snd_edge   = sended & ~sended_q;

    always_comb begin
        state_d   = state_q;
        pointer_d = pointer_q;
        regwr_d   = 1'b0;
        regaddr_d = regaddr_q;
        i2c_we    = 1'b0;
        ptr_load  = 1'b0;
        if (start) begin
            state_d = PTR;
        end else if (rcv_edge) begin
            case (state_q)
                PTR: begin
                    ptr_load  = 1'b1;
                    pointer_d = datareceive[3:0];
                    state_d   = DATA;
                end
                DATA: begin
                    i2c_we    = 1'b1;
                    regwr_d   = 1'b1;
                    regaddr_d = pointer_q;
                end
                default: ;
            endcase
        end
        // A write and a read-ACK in the same cycle still move the pointer by one.
        if (!ptr_load && (i2c_we || snd_edge)) begin
            pointer_d = pointer_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            pointer_q  <= 4'h0;
            regwr_q    <= 1'b0;
            regaddr_q  <= 4'h0;
            received_q <= 1'b0;
            sended_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pointer_q  <= pointer_d;
            regwr_q    <= regwr_d;
            regaddr_q  <= regaddr_d;
            received_q <= received_d;
            sended_q   <= sended_d;
        end
    end

    // I2C write takes priority over a host write to the same index.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_reg
            assign regs_d[gi] = (i2c_we && pointer_q == 4'(gi)) ? datareceive :
                                (hostwe && hostaddr == 4'(gi))  ? hostwdata   :
                                regs_q[gi];
            always_ff @(posedge clk) begin
                if (!reset) begin
                    regs_q[gi] <= 8'h00;
                end else begin
                    regs_q[gi] <= regs_d[gi];
                end
            end
        end
    endgenerate

    assign datasend  = regs_q[pointer_q];
    assign hostrdata = regs_q[hostaddr];
    assign regwr     = regwr_q;
    assign regaddr   = regaddr_q;
    assign pointer   = pointer_q;

endmodule
